// File: rtl/comb_pkg.sv
// Shared definitions for the comb equalizer: pipeline latency, default
// widths and saturation-bound helpers used by the optional clamp stage.
package comb_pkg;

  // Clocks from an accepted strobe_in to the matching strobe_out.
  localparam int COMB_LATENCY = 2;

  localparam int DEF_BIT_WIDTH  = 16;
  localparam int DEF_DELAY_LOG2 = 3;
  localparam int DEF_FB_SHIFT   = 3;

  // Largest value representable in a w-bit two's complement word.
  function automatic longint sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 32'd1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic longint sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 32'd1));
  endfunction

endpackage

// File: rtl/comb_eq_lane.sv
// One I or Q lane of the inverse comb: history ring, stage-1 capture,
// stage-2 arithmetic and output reduction.
// Optional feature macro: COMB_EQ_SAT_EN (clamp to output range, flag overflow);
// without it the low BIT_WIDTH bits of the accumulator are taken.
module comb_eq_lane
  import comb_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int DELAY_LOG2 = DEF_DELAY_LOG2,
  parameter int FB_SHIFT   = DEF_FB_SHIFT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         strobe,
  input  logic [DELAY_LOG2-1:0]        wr_idx,
  input  logic                         hist_ok,
  input  logic                         bypass,
  input  logic                         load_out,
  input  logic signed [BIT_WIDTH-1:0]  sample_in,
  output logic signed [BIT_WIDTH-1:0]  sample_out,
  output logic                         ovf
);

  localparam int D     = 1 << DELAY_LOG2;
  // Final result o*2^S + o_D*(2^S-1) always fits in this width, so
  // modular arithmetic on the intermediate (o+o_D)<<S still lands exact.
  localparam int ACC_W = BIT_WIDTH + FB_SHIFT + 1;

  logic signed [BIT_WIDTH-1:0] hist_mem [D];

  logic signed [BIT_WIDTH-1:0] samp_q, samp_d;
  logic signed [BIT_WIDTH-1:0] od_q, od_d;
  logic                        byp_q, byp_d;
  logic signed [BIT_WIDTH-1:0] out_q, out_d;

  logic signed [ACC_W-1:0]     o_ext_s, od_ext_s, acc_s;
  logic signed [BIT_WIDTH-1:0] res_s;

  // History ring write; contents are never reset, the fill mask hides stale data.
  always_ff @(posedge clock) begin
    if (strobe) begin
      hist_mem[wr_idx] <= sample_in;
    end
  end

  // Stage-1 capture: sample, delayed sample (read before the write above), bypass.
  always_comb begin
    samp_d = samp_q;
    od_d   = od_q;
    byp_d  = byp_q;
    if (strobe) begin
      samp_d = sample_in;
      od_d   = hist_ok ? hist_mem[wr_idx] : {BIT_WIDTH{1'b0}};
      byp_d  = bypass;
    end else begin
      samp_d = samp_q;
    end
  end

  // Stage-2 arithmetic on the captured pair.
  always_comb begin
    o_ext_s  = ACC_W'(samp_q);
    od_ext_s = ACC_W'(od_q);
    acc_s    = ((o_ext_s + od_ext_s) <<< FB_SHIFT) - od_ext_s;
  end

`ifdef COMB_EQ_SAT_EN
  localparam logic signed [ACC_W-1:0]     ACC_MAX = ACC_W'(sat_max(BIT_WIDTH));
  localparam logic signed [ACC_W-1:0]     ACC_MIN = ACC_W'(sat_min(BIT_WIDTH));
  localparam logic signed [BIT_WIDTH-1:0] OUT_MAX = BIT_WIDTH'(sat_max(BIT_WIDTH));
  localparam logic signed [BIT_WIDTH-1:0] OUT_MIN = BIT_WIDTH'(sat_min(BIT_WIDTH));

  logic clamp_s;
  logic ovf_q, ovf_d;

  // Clamp the accumulator into the output range and note when it happened.
  always_comb begin
    res_s   = acc_s[BIT_WIDTH-1:0];
    clamp_s = 1'b0;
    if (acc_s > ACC_MAX) begin
      res_s   = OUT_MAX;
      clamp_s = 1'b1;
    end else if (acc_s < ACC_MIN) begin
      res_s   = OUT_MIN;
      clamp_s = 1'b1;
    end else begin
      res_s   = acc_s[BIT_WIDTH-1:0];
      clamp_s = 1'b0;
    end
  end

  // Overflow flag follows each loaded result; bypassed samples never overflow.
  always_comb begin
    ovf_d = ovf_q;
    if (load_out) begin
      ovf_d = byp_q ? 1'b0 : clamp_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic [FB_SHIFT:0] acc_unused;

  // Wrap: keep the low bits of the accumulator.
  always_comb begin
    res_s      = acc_s[BIT_WIDTH-1:0];
    acc_unused = acc_s[ACC_W-1:BIT_WIDTH];
  end

  assign ovf = 1'b0;
`endif

  // Output selection: new result on load, otherwise hold the last one.
  always_comb begin
    out_d = out_q;
    if (load_out) begin
      out_d = byp_q ? samp_q : res_s;
    end else begin
      out_d = out_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      samp_q <= {BIT_WIDTH{1'b0}};
      od_q   <= {BIT_WIDTH{1'b0}};
      byp_q  <= 1'b0;
      out_q  <= {BIT_WIDTH{1'b0}};
    end else begin
      samp_q <= samp_d;
      od_q   <= od_d;
      byp_q  <= byp_d;
      out_q  <= out_d;
    end
  end

  assign sample_out = out_q;

endmodule

// File: rtl/comb_equalizer.sv
// Inverse (feed-forward) comb for complex I/Q samples:
//   x = ((o + o_D) << S) - o_D, o_D being the sample 2^DELAY_LOG2 strobes back.
// Optional feature macro: COMB_EQ_SAT_EN (saturate results, drive ovf_out).
// Write pointer, warm-up count and valid pipeline are shared by both lanes.
module comb_equalizer
  import comb_pkg::*;
#(
  parameter int BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int DELAY_LOG2 = DEF_DELAY_LOG2,
  parameter int FB_SHIFT   = DEF_FB_SHIFT
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 strobe_in,
  input  logic                 clear,
  input  logic                 bypass,
  input  logic [BIT_WIDTH-1:0] i_in,
  input  logic [BIT_WIDTH-1:0] q_in,
  output logic                 strobe_out,
  output logic [BIT_WIDTH-1:0] i_out,
  output logic [BIT_WIDTH-1:0] q_out,
  output logic                 ovf_out
);

  localparam int D = 1 << DELAY_LOG2;
  localparam logic [DELAY_LOG2:0] FILL_FULL = (DELAY_LOG2 + 1)'(D);

  logic [DELAY_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DELAY_LOG2:0]     fill_cnt_q, fill_cnt_d;
  logic [COMB_LATENCY-1:0] valid_q, valid_d;

  logic [DELAY_LOG2-1:0]   wr_idx_s;
  logic                    hist_ok_s;
  logic                    ovf_i_s, ovf_q_s;
  logic [BIT_WIDTH-1:0]    i_res_s, q_res_s;

  // A clear in the same cycle as a strobe makes that sample the first of a fresh history.
  always_comb begin
    wr_idx_s  = wr_ptr_q;
    hist_ok_s = 1'b0;
    if (clear) begin
      wr_idx_s  = {DELAY_LOG2{1'b0}};
      hist_ok_s = 1'b0;
    end else begin
      wr_idx_s  = wr_ptr_q;
      hist_ok_s = (fill_cnt_q == FILL_FULL);
    end
  end

  // Next write pointer and warm-up count.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    if (clear) begin
      wr_ptr_d   = strobe_in ? DELAY_LOG2'(1) : {DELAY_LOG2{1'b0}};
      fill_cnt_d = strobe_in ? (DELAY_LOG2 + 1)'(1) : {(DELAY_LOG2 + 1){1'b0}};
    end else if (strobe_in) begin
      wr_ptr_d   = wr_ptr_q + DELAY_LOG2'(1);
      fill_cnt_d = (fill_cnt_q == FILL_FULL) ? fill_cnt_q : fill_cnt_q + (DELAY_LOG2 + 1)'(1);
    end else begin
      wr_ptr_d   = wr_ptr_q;
      fill_cnt_d = fill_cnt_q;
    end
  end

  // Valid pipeline: one bit per stage, so gaps in strobe_in are preserved.
  always_comb begin
    valid_d = {valid_q[COMB_LATENCY-2:0], strobe_in};
  end

  // Shared control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= {DELAY_LOG2{1'b0}};
      fill_cnt_q <= {(DELAY_LOG2 + 1){1'b0}};
      valid_q    <= {COMB_LATENCY{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= valid_d;
    end
  end

  comb_eq_lane #(
    .BIT_WIDTH  (BIT_WIDTH),
    .DELAY_LOG2 (DELAY_LOG2),
    .FB_SHIFT   (FB_SHIFT)
  ) u_lane_i (
    .clock      (clock),
    .reset_n    (reset_n),
    .strobe     (strobe_in),
    .wr_idx     (wr_idx_s),
    .hist_ok    (hist_ok_s),
    .bypass     (bypass),
    .load_out   (valid_q[0]),
    .sample_in  (i_in),
    .sample_out (i_res_s),
    .ovf        (ovf_i_s)
  );

  comb_eq_lane #(
    .BIT_WIDTH  (BIT_WIDTH),
    .DELAY_LOG2 (DELAY_LOG2),
    .FB_SHIFT   (FB_SHIFT)
  ) u_lane_q (
    .clock      (clock),
    .reset_n    (reset_n),
    .strobe     (strobe_in),
    .wr_idx     (wr_idx_s),
    .hist_ok    (hist_ok_s),
    .bypass     (bypass),
    .load_out   (valid_q[0]),
    .sample_in  (q_in),
    .sample_out (q_res_s),
    .ovf        (ovf_q_s)
  );

  assign strobe_out = valid_q[COMB_LATENCY-1];
  assign i_out      = i_res_s;
  assign q_out      = q_res_s;
  assign ovf_out    = ovf_i_s | ovf_q_s;

endmodule

// File: tb/tb_comb_equalizer.sv
// Directed bench for comb_equalizer with a scoreboard fed by an independent
// model (sample history kept as a plain list since the last clear/reset).
module tb_comb_equalizer;

  localparam int BW = 16;
  localparam int D  = 8;
  localparam int S  = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          strobe_in;
  logic          clear;
  logic          bypass;
  logic [BW-1:0] i_in;
  logic [BW-1:0] q_in;
  logic          strobe_out;
  logic [BW-1:0] i_out;
  logic [BW-1:0] q_out;
  logic          ovf_out;

  comb_equalizer #(
    .BIT_WIDTH  (BW),
    .DELAY_LOG2 (3),
    .FB_SHIFT   (S)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .strobe_in  (strobe_in),
    .clear      (clear),
    .bypass     (bypass),
    .i_in       (i_in),
    .q_in       (q_in),
    .strobe_out (strobe_out),
    .i_out      (i_out),
    .q_out      (q_out),
    .ovf_out    (ovf_out)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [BW-1:0] i;
    logic [BW-1:0] q;
    logic          ovf;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   hist_i[$];
  int   hist_q[$];
  logic pipe0 = 1'b0;
  logic pipe1 = 1'b0;
  exp_t held  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Golden result for one lane, reduced to the output width.
  task automatic lane_model(input int o, input int od, output logic [BW-1:0] r, output logic ov);
    int x;
    x  = ((o + od) * (1 << S)) - od;
    ov = 1'b0;
`ifdef COMB_EQ_SAT_EN
    if (x > 32767) begin
      r  = 16'h7fff;
      ov = 1'b1;
    end else if (x < -32768) begin
      r  = 16'h8000;
      ov = 1'b1;
    end else begin
      r = x[BW-1:0];
    end
`else
    r = x[BW-1:0];
`endif
  endtask

  // Compare whatever the DUT shows at this negedge, then advance the strobe pipe.
  task automatic observe();
    chk("strobe_out", {31'd0, strobe_out}, {31'd0, pipe1});
    if (pipe1) begin
      chk("sb_nonempty", {31'd0, (sb.size() > 0)}, 32'd1);
      if (sb.size() > 0) held = sb.pop_front();
    end
    chk("i_out", {16'd0, i_out}, {16'd0, held.i});
    chk("q_out", {16'd0, q_out}, {16'd0, held.q});
    chk("ovf_out", {31'd0, ovf_out}, {31'd0, held.ovf});
    pipe1 = pipe0;
  endtask

  // One clock of stimulus plus the matching model update.
  task automatic tick(input logic stb, input logic [BW-1:0] i, input logic [BW-1:0] q,
                      input logic clr, input logic byp);
    int            od_i, od_q;
    logic [BW-1:0] ri, rq;
    logic          oi, oq;
    exp_t          e;
    @(negedge clock);
    observe();
    strobe_in = stb;
    i_in      = i;
    q_in      = q;
    clear     = clr;
    bypass    = byp;
    pipe0     = stb;
    if (clr) begin
      hist_i.delete();
      hist_q.delete();
    end
    if (stb) begin
      od_i = (hist_i.size() == D) ? hist_i[0] : 0;
      od_q = (hist_q.size() == D) ? hist_q[0] : 0;
      lane_model($signed(i), od_i, ri, oi);
      lane_model($signed(q), od_q, rq, oq);
      if (byp) begin
        e.i = i;  e.q = q;  e.ovf = 1'b0;
      end else begin
        e.i = ri; e.q = rq; e.ovf = oi | oq;
      end
      sb.push_back(e);
      hist_i.push_back($signed(i));
      hist_q.push_back($signed(q));
      if (hist_i.size() > D) void'(hist_i.pop_front());
      if (hist_q.size() > D) void'(hist_q.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    strobe_in = 1'b0;
    clear     = 1'b0;
    bypass    = 1'b0;
    #1;
    chk("rst_strobe", {31'd0, strobe_out}, 32'd0);
    chk("rst_i", {16'd0, i_out}, 32'd0);
    chk("rst_q", {16'd0, q_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_out}, 32'd0);
    sb.delete();
    hist_i.delete();
    hist_q.delete();
    pipe0 = 1'b0;
    pipe1 = 1'b0;
    held  = '0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    strobe_in = 1'b0;
    clear     = 1'b0;
    bypass    = 1'b0;
    i_in      = 16'd0;
    q_in      = 16'd0;
    repeat (2) @(negedge clock);
    chk("init_strobe", {31'd0, strobe_out}, 32'd0);
    chk("init_i", {16'd0, i_out}, 32'd0);
    chk("init_ovf", {31'd0, ovf_out}, 32'd0);
    reset_n = 1'b1;

    // Impulse on I: 8 at n=0, 7 at n=8.
    tick(1'b1, 16'd1, 16'd0, 1'b0, 1'b0);
    for (int n = 0; n < 15; n++) tick(1'b1, 16'd0, 16'd0, 1'b0, 1'b0);

    // Step of 100 after a clear: 800 x8 then 1500.
    tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
    for (int n = 0; n < 12; n++) tick(1'b1, 16'd100, 16'hff9c, 1'b0, 1'b0);

    // Large constant exercising overflow on both signs.
    tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) tick(1'b1, 16'd4096, 16'hec78, 1'b0, 1'b0);

    // Random I/Q, strobe every third clock (clear+strobe in the same cycle first).
    tick(1'b1, 16'd1234, 16'd4321, 1'b1, 1'b0);
    for (int n = 0; n < 30; n++) begin
      tick(1'b1, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
      tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    end

    // Reset mid-stream, then a fresh step.
    for (int n = 0; n < 5; n++) tick(1'b1, 16'd77, 16'd55, 1'b0, 1'b0);
    do_reset();
    for (int n = 0; n < 12; n++) tick(1'b1, 16'd100, 16'd0, 1'b0, 1'b0);

    // Clear after 20 samples, bypass window, then resume.
    for (int n = 0; n < 8; n++) tick(1'b1, 16'd100, 16'd0, 1'b0, 1'b0);
    tick(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) tick(1'b1, 16'd100, 16'd0, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) tick(1'b1, 16'd100, 16'd0, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) tick(1'b1, 16'd100, 16'd0, 1'b0, 1'b0);

    // Drain and confirm every expected result was produced.
    for (int n = 0; n < 4; n++) tick(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
